mini_alu_div_param: RTL
=======================

// Module: mini_alu_div_param
// PURPOSE
//  Parametrised multi-cycle restoring divider for the mini ALU; successor to the fixed 16-bit DIV unit.
//  Adds a WIDTH parameter, a per-operation signed/unsigned mode, a busy flag with start handshake,
//  explicit divide-by-zero and signed-overflow results, and held outputs.
//  Sits beside the ALU ADD/MUL units; the ALU control FSM drives start and samples results on valid.
// PARAMETERS
//  WIDTH      16  operand/result width, >= 2
//  SIGNED_EN  1   1: signed_op honoured; 0: signed_op ignored, always unsigned
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-low reset
//  start      in   1      request; sampled only while busy==0
//  signed_op  in   1      1 = two's-complement divide (only if SIGNED_EN==1); sampled with start
//  X          in   WIDTH  dividend; sampled with start
//  Y          in   WIDTH  divisor; sampled with start
//  busy       out  1      1 while an operation is in flight (state != IDLE)
//  quot       out  WIDTH  quotient, registered, held until the next accepted start
//  rem        out  WIDTH  remainder, registered, held until the next accepted start
//  div_zero   out  1      registered; Y was 0 for the completed op
//  overflow   out  1      registered; signed MIN/-1 for the completed op
//  valid      out  1      registered, one-cycle pulse: results are final
// BEHAVIOUR
//  Reset: state=IDLE; count=0; quot=rem=0; div_zero=overflow=valid=busy=0. Async assert, any state; in-flight op is discarded.
//  FSM states:
//   IDLE -> CALC on start (Y!=0). IDLE -> ZERO on start (Y==0).
//   CALC -> FIX after WIDTH iterations. FIX -> IDLE. ZERO -> IDLE.
//  Accept (edge 0, IDLE & start): latch sign_q=s&(X[W-1]^Y[W-1]) and sign_r=s&X[W-1], where s=signed_op&SIGNED_EN.
//   Latch magnitudes |X|,|Y| (unsigned if s==0).
//   Clear div_zero, overflow and valid. quot/rem keep their previous values until FIX/ZERO.
//  CALC: one restoring step per cycle on a (2*WIDTH+1)-bit partial register.
//   Shift left 1; trial = upper - |Y|.
//   If trial is non-negative: commit the difference and set quotient LSB=1. Else restore and set LSB=0.
//   A counter of clog2(WIDTH) bits ends CALC after exactly WIDTH steps (edges 1..WIDTH).
//  FIX (edge WIDTH+1): quot = sign_q ? -qmag : qmag; rem = sign_r ? -rmag : rmag. valid=1.
//   Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
//   overflow=1 iff s & X==MIN & Y==all-ones. Then quot=MIN (natural wrap of -2^(W-1)) and rem=0.
//  ZERO (edge 1): quot=all-ones, rem=X (raw input bits), div_zero=1, valid=1, overflow=0. No iterations.
//  Latency from the accept edge to the edge that raises valid: WIDTH+1 normally, 1 for divide-by-zero.
//   Throughput: one op per WIDTH+2 cycles.
//  valid is high for exactly one cycle, which is an IDLE cycle.
//   start in that cycle is accepted; back-to-back ops have no gap.
//  start while busy==1 is ignored; X/Y/signed_op changes while busy do not affect the op.
//  busy is decoded from the state register: rises the cycle after accept, falls with valid.
//  Unsigned mode with MSB-set operands is valid. X=0 gives quot=0 and rem=0.
// TESTING
//  1 WIDTH=16 unsigned: X=100, Y=7, start 1 cycle -> busy 17 cycles; valid at edge 17; quot=14, rem=2, flags 0.
//  2 signed: X=0xFF9C(-100), Y=7 -> quot=0xFFF2(-14), rem=0xFFFE(-2).
//    Then X=100, Y=0xFFF9(-7) -> quot=0xFFF2, rem=2.
//  3 divide-by-zero: X=0x1234, Y=0 -> valid at edge 1; quot=0xFFFF, rem=0x1234, div_zero=1.
//    Next op clears div_zero at accept.
//  4 signed overflow: X=0x8000, Y=0xFFFF -> quot=0x8000, rem=0, overflow=1.
//    Same operands unsigned -> quot=0, rem=0x8000, overflow=0.
//  5 handshake: pulse start again mid-op with other X/Y -> ignored, first result unchanged.
//    start during valid -> next op accepted, completes 17 edges later.
//  6 rst low at CALC cycle 5 -> all outputs 0 immediately, state IDLE. WIDTH=8, SIGNED_EN=0: X=255, Y=16 -> quot=15, rem=15, valid at edge 9.

Source files
------------

// File: rtl/mini_alu_div_param.sv
// mini_alu_div_param: multi-cycle restoring divider with signed mode, divide-by-zero and overflow flags
module mini_alu_div_param #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero,
    output logic             overflow,
    output logic             valid
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_t;
    state_t state, state_nx;
    logic [CW-1:0] count;
    logic [2*WIDTH:0] p, p_sh, p_step;
    logic [WIDTH:0] trial;
    logic [WIDTH-1:0] ymag, xabs, yabs;
    logic s, sign_q, sign_r, ovf_pend, accept;
    assign s      = signed_op & SIGNED_EN;
    assign xabs   = (s & X[WIDTH-1]) ? -X : X;
    assign yabs   = (s & Y[WIDTH-1]) ? -Y : Y;
    assign accept = (state == IDLE) & start;
    assign busy   = state != IDLE;
    // upper WIDTH+1 bits hold the partial remainder, lower WIDTH bits shift the dividend into the quotient
    assign p_sh   = p << 1;
    assign trial  = p_sh[2*WIDTH:WIDTH] - {1'b0, ymag};
    assign p_step = trial[WIDTH] ? p_sh : {trial, p_sh[WIDTH-1:1], 1'b1};
    always_comb begin
        state_nx = (state == IDLE) ? (start ? ((Y == '0) ? ZERO : CALC) : IDLE) :
                   (state == CALC) ? ((count == CW'(WIDTH - 1)) ? FIX : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            p        <= '0;
            ymag     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            ovf_pend <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                sign_q   <= s & (X[WIDTH-1] ^ Y[WIDTH-1]);
                sign_r   <= s & X[WIDTH-1];
                ymag     <= yabs;
                // divide-by-zero keeps the raw dividend so it can be returned as the remainder
                p        <= {(WIDTH + 1)'(0), (Y == '0) ? X : xabs};
                count    <= '0;
                ovf_pend <= s & (X == {1'b1, {(WIDTH - 1){1'b0}}}) & (&Y);
                div_zero <= 1'b0;
                overflow <= 1'b0;
            end else if (state == CALC) begin
                p     <= p_step;
                count <= count + CW'(1);
            end else if (state == FIX) begin
                quot     <= sign_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
                rem      <= sign_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
                overflow <= ovf_pend;
                valid    <= 1'b1;
            end else if (state == ZERO) begin
                quot     <= '1;
                rem      <= p[WIDTH-1:0];
                div_zero <= 1'b1;
                valid    <= 1'b1;
            end
        end
    end
endmodule
